player_hit_ctrl: RTL and testbench
==================================

// Module: player_hit_ctrl
// PURPOSE
//  Generates player_hit and owns the hit/death sequence for the player.
//  - Single-cycle player_hit pulse into the lives counter.
//  - Mercy-invulnerability window and sprite blink after each hit.
//  - Death animation window and game-over hold.
//  - Sits between the collision detector and the lives counter; consumes player_died.
// PARAMETERS
//  INVULN_FRAMES      120  frames of invulnerability after a hit (legal 1..255)
//  BLINK_HALF_FRAMES  8    frames per blink half-period in invulnerability (legal 1..255)
//  DEATH_FRAMES       90   frames of death animation before game over (legal 1..255)
// PORTS
//  clk                  in   1  system clock
//  reset                in   1  synchronous, active-high reset
//  startOfFrame         in   1  one-cycle pulse per video frame
//  explosion_collision  in   1  level: player pixel overlaps explosion pixel
//  enemy_collision      in   1  level: player pixel overlaps enemy pixel
//  player_died          in   1  level from lives counter: lives == 0
//  score_reset          in   1  one-cycle game-restart request
//  player_hit           out  1  one-cycle pulse: decrement lives
//  invulnerable         out  1  high while in INVULN
//  player_blink         out  1  1 = hide player sprite this frame
//  game_over            out  1  high while in GAME_OVER
//  hit_count            out  8  hits since restart, saturating at 255
// BEHAVIOUR
//  Reset values (all outputs): state=ALIVE, player_hit=0, invulnerable=0,
//   player_blink=0, game_over=0, hit_count=0, frame_cnt=0, blink_cnt=0.
//  Priority each cycle: reset > score_reset > state transitions.
//   score_reset clears counters and goes to ALIVE; no player_hit that cycle.
//  coll = explosion_collision | enemy_collision. Level-sensitive, sampled only in ALIVE.
//  frame_cnt and blink_cnt are 8-bit and advance only on startOfFrame.
//  States:
//   ALIVE     player_died=1 -> DYING, no pulse (lives zeroed externally).
//             else coll=1 -> HIT.
//   HIT       Exactly one cycle; player_hit=1 (registered, Moore).
//             Pulse appears one cycle after coll is sampled high.
//             hit_count+1, saturating at 255.
//             Clear frame_cnt and blink_cnt; set player_blink=1; -> INVULN.
//   INVULN    invulnerable=1; coll ignored.
//             player_died=1 -> DYING. Checked first; covers the lives
//              counter's 1-cycle update lag after the pulse.
//             On startOfFrame:
//              frame_cnt==INVULN_FRAMES-1 -> ALIVE, player_blink=0.
//              else frame_cnt+1; blink_cnt+1.
//              blink_cnt==BLINK_HALF_FRAMES-1 -> blink_cnt=0, toggle player_blink.
//             A startOfFrame in the HIT cycle itself is not counted.
//   DYING     player_blink=1 constant; invulnerable=0; frame_cnt cleared on entry.
//             On startOfFrame: frame_cnt==DEATH_FRAMES-1 -> GAME_OVER, else +1.
//   GAME_OVER game_over=1; player_blink=1. Holds until score_reset.
//  Collision held across the end of INVULN: new HIT on the cycle after ALIVE is
//   re-entered. Intentional; the player must leave the hazard.
//  Outputs in ALIVE: player_blink=0, invulnerable=0, game_over=0, player_hit=0.
// TESTING (sim params INVULN_FRAMES=4, BLINK_HALF_FRAMES=1, DEATH_FRAMES=3)
//  1. reset 1 cycle, coll=1 for 1 cycle at t0 -> player_hit=1 only at t0+1;
//     hit_count=1; invulnerable=1 from t0+2.
//  2. After hit, 4 startOfFrame pulses with coll held 1 -> no extra pulse;
//     player_blink 1,0,1,0 per frame; ALIVE after 4th; next hit 1 cycle later.
//  3. player_died=1 two cycles after player_hit -> DYING; blink=1;
//     3 startOfFrame -> game_over=1; holds until score_reset.
//  4. score_reset during INVULN and during GAME_OVER -> next cycle ALIVE,
//     all outputs 0, hit_count=0; score_reset+coll same cycle -> no pulse.
//  5. 256 hits (coll pulsed, frames advanced) -> hit_count saturates at 255.
//  6. reset asserted mid-DYING -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/player_hit_ctrl.sv
// Player hit/death sequencer: turns collisions into single-cycle hit pulses and
// runs the mercy-invulnerability blink, the death animation and the game-over hold.
module player_hit_ctrl #(
  parameter int INVULN_FRAMES     = 120,
  parameter int BLINK_HALF_FRAMES = 8,
  parameter int DEATH_FRAMES      = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       explosion_collision,
  input  logic       enemy_collision,
  input  logic       player_died,
  input  logic       score_reset,
  output logic       player_hit,
  output logic       invulnerable,
  output logic       player_blink,
  output logic       game_over,
  output logic [7:0] hit_count
);

  typedef enum logic [2:0] {
    ALIVE,
    HIT,
    INVULN,
    DYING,
    GAME_OVER
  } state_t;

  localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_HALF_FRAMES - 1);
  localparam logic [7:0] DEATH_LAST  = 8'(DEATH_FRAMES - 1);

  state_t     state, state_n;
  logic [7:0] frame_cnt, frame_cnt_n;
  logic [7:0] blink_cnt, blink_cnt_n;
  logic [7:0] hit_cnt, hit_cnt_n;
  logic       blink, blink_n;
  logic       coll;

  assign coll = explosion_collision | enemy_collision;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; that is what keeps always_comb from inferring a latch.
  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    blink_cnt_n = blink_cnt;
    hit_cnt_n   = hit_cnt;
    blink_n     = blink;

    if (score_reset) begin
      state_n     = ALIVE;
      frame_cnt_n = '0;
      blink_cnt_n = '0;
      hit_cnt_n   = '0;
      blink_n     = 1'b0;
    end else begin
      unique case (state)
        ALIVE: begin
          blink_n = 1'b0;
          // Lives already at zero: go straight to the death animation, no pulse.
          if (player_died) begin
            state_n     = DYING;
            frame_cnt_n = '0;
            blink_n     = 1'b1;
          end else if (coll) begin
            state_n     = HIT;
            hit_cnt_n   = (hit_cnt == 8'hFF) ? hit_cnt : hit_cnt + 8'd1;
            frame_cnt_n = '0;
            blink_cnt_n = '0;
            blink_n     = 1'b1;
          end
        end
        HIT: state_n = INVULN;
        INVULN: begin
          // The lives counter lags the pulse by a cycle, so death wins here.
          if (player_died) begin
            state_n     = DYING;
            frame_cnt_n = '0;
            blink_n     = 1'b1;
          end else if (startOfFrame) begin
            if (frame_cnt == INVULN_LAST) begin
              state_n = ALIVE;
              blink_n = 1'b0;
            end else begin
              frame_cnt_n = frame_cnt + 8'd1;
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt_n = '0;
                blink_n     = ~blink;
              end else begin
                blink_cnt_n = blink_cnt + 8'd1;
              end
            end
          end
        end
        DYING: begin
          blink_n = 1'b1;
          if (startOfFrame) begin
            if (frame_cnt == DEATH_LAST) state_n = GAME_OVER;
            else frame_cnt_n = frame_cnt + 8'd1;
          end
        end
        GAME_OVER: blink_n = 1'b1;
        default: state_n = ALIVE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ALIVE;
      frame_cnt <= '0;
      blink_cnt <= '0;
      hit_cnt   <= '0;
      blink     <= 1'b0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_cnt_n;
      blink_cnt <= blink_cnt_n;
      hit_cnt   <= hit_cnt_n;
      blink     <= blink_n;
    end
  end

  assign player_hit   = (state == HIT);
  assign invulnerable = (state == INVULN);
  assign game_over    = (state == GAME_OVER);
  assign player_blink = blink;
  assign hit_count    = hit_cnt;

endmodule

// File: tb/tb_player_hit_ctrl.sv
// Bench for player_hit_ctrl: expected hit pulses are queued by the stimulus and
// matched by a monitor; level outputs are checked directly against hand values.
module tb_player_hit_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       explosion_collision = 1'b0;
  logic       enemy_collision = 1'b0;
  logic       player_died = 1'b0;
  logic       score_reset = 1'b0;
  logic       player_hit;
  logic       invulnerable;
  logic       player_blink;
  logic       game_over;
  logic [7:0] hit_count;

  typedef struct {
    int         cycle;
    logic [7:0] count;
  } hit_exp_t;

  hit_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  player_hit_ctrl #(
    .INVULN_FRAMES(4),
    .BLINK_HALF_FRAMES(1),
    .DEATH_FRAMES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .startOfFrame(startOfFrame),
    .explosion_collision(explosion_collision),
    .enemy_collision(enemy_collision),
    .player_died(player_died),
    .score_reset(score_reset),
    .player_hit(player_hit),
    .invulnerable(invulnerable),
    .player_blink(player_blink),
    .game_over(game_over),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every hit pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (player_hit === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_hit_pulse", 1, 0);
      end else begin
        hit_exp_t e;
        e = exp_q.pop_front();
        check("hit_pulse_cycle", cyc, e.cycle);
        check("hit_pulse_count", int'(hit_count), int'(e.count));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Queue a pulse for the collision about to be sampled on the next edge.
  task automatic expect_hit(input logic [7:0] count);
    hit_exp_t e;
    e.cycle = cyc + 1;
    e.count = count;
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hit"}, int'(player_hit), 0);
    check({tag, "_invuln"}, int'(invulnerable), 0);
    check({tag, "_blink"}, int'(player_blink), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
    check({tag, "_hit_count"}, int'(hit_count), 0);
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic blink_exp[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    step();
    step();
    reset = 1'b0;
    check_idle("reset");

    // Single-cycle collision -> one pulse, then invulnerability.
    enemy_collision = 1'b1;
    expect_hit(8'd1);
    step();
    enemy_collision = 1'b0;
    check("hit_cycle_invuln", int'(invulnerable), 0);
    step();
    check("invuln_after_hit", int'(invulnerable), 1);
    check("hit_count_one", int'(hit_count), 1);

    // Collision held through invulnerability; blink toggles each frame.
    explosion_collision = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("blink_frame%0d", i), int'(player_blink), int'(blink_exp[i]));
      check($sformatf("invuln_frame%0d", i), int'(invulnerable), 1);
      frame();
    end
    check("alive_invuln", int'(invulnerable), 0);
    check("alive_blink", int'(player_blink), 0);
    expect_hit(8'd2);
    step();
    explosion_collision = 1'b0;
    step();
    check("second_invuln", int'(invulnerable), 1);

    // Lives reach zero two cycles after the pulse -> death animation.
    player_died = 1'b1;
    step();
    check("dying_blink", int'(player_blink), 1);
    check("dying_invuln", int'(invulnerable), 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dying_game_over%0d", i), int'(game_over), 0);
      frame();
      step();
    end
    check("game_over_set", int'(game_over), 1);
    check("game_over_blink", int'(player_blink), 1);
    enemy_collision = 1'b1;
    frame();
    step();
    check("game_over_hold", int'(game_over), 1);

    // Restart from game over with a collision on the same cycle.
    player_died = 1'b0;
    score_reset = 1'b1;
    step();
    score_reset = 1'b0;
    check_idle("restart_go");
    expect_hit(8'd1);
    step();
    enemy_collision = 1'b0;
    step();
    check("restart_invuln", int'(invulnerable), 1);
    score_reset = 1'b1;
    step();
    score_reset = 1'b0;
    check_idle("restart_inv");
    enemy_collision = 1'b1;
    score_reset = 1'b1;
    step();
    enemy_collision = 1'b0;
    score_reset = 1'b0;
    step();
    check_idle("reset_with_coll");

    // Saturation of the hit counter.
    for (int i = 1; i <= 256; i++) begin
      enemy_collision = 1'b1;
      expect_hit((i > 255) ? 8'd255 : 8'(i));
      step();
      enemy_collision = 1'b0;
      step();
      for (int f = 0; f < 4; f++) frame();
    end
    check("hit_count_saturated", int'(hit_count), 255);

    // Reset in the middle of the death animation.
    player_died = 1'b1;
    step();
    check("pre_reset_blink", int'(player_blink), 1);
    frame();
    reset = 1'b1;
    step();
    reset = 1'b0;
    player_died = 1'b0;
    check_idle("mid_dying_reset");

    step();
    step();
    check("pending_pulses", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
